// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory responder.
//
// This block is the target side of the processor data-memory request interface.
// It accepts one read or one write at a time. It waits LATENCY cycles, then does
// the access and pulses ready for one cycle. Inputs are ignored from acceptance
// until the end of the ready cycle.
//
// Optional feature macro: DM_RANGE_CHECK_EN.
//   - When defined, an address >= DEPTH raises err together with ready.
//     The write is dropped, and a read returns 0.
//   - When undefined, addresses wrap modulo DEPTH and err is tied 0.
//
// Ports:
//   clk       in   clock; all state changes on the rising edge
//   rst       in   asynchronous active-low reset
//   memRead   in   read request
//   memWrite  in   write request; wins over memRead
//   address   in   word address (ADDR_W)
//   writeData in   write data (DATA_W)
//   readData  out  last read result, held until the next read completes
//   ready     out  one-cycle completion pulse
//   busy      out  request accepted and not yet completed
//   err       out  range error, pulses with ready (0 unless DM_RANGE_CHECK_EN)
module dm_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IdxW-1:0] idx;
  logic            access;
  logic            range_err;
  logic            mem_we;

  // The upper address bits are dropped here, so the index wraps modulo DEPTH.
  assign idx    = addr_q[IdxW-1:0];
  assign access = (state_q == StWait) && (cnt_q == 4'd0);
  assign mem_we = access && write_q && !range_err;

`ifdef DM_RANGE_CHECK_EN
  logic err_q;
  assign range_err = (64'(addr_q) >= 64'(DEPTH));
  assign err       = err_q;
`else
  assign range_err = 1'b0;
  assign err       = 1'b0;
`endif

  // The array has no reset. Its contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DM_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (memRead || memWrite) begin
            addr_q  <= address;
            wdata_q <= writeData;
            write_q <= memWrite;
            cnt_q   <= 4'(LATENCY);
            busy_q  <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Writes never touch readData.
            if (!write_q) begin
              rdata_q <= range_err ? '0 : mem[idx];
            end
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef DM_RANGE_CHECK_EN
            err_q   <= range_err;
`endif
            state_q <= StResp;
          end
        end
        StResp: begin
          ready_q <= 1'b0;
`ifdef DM_RANGE_CHECK_EN
          err_q   <= 1'b0;
`endif
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign readData = rdata_q;
  assign ready    = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder (DEPTH=256, LATENCY=2).
module tb_dm_responder;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

`ifdef DM_RANGE_CHECK_EN
  localparam logic RangeEn = 1'b1;
`else
  localparam logic RangeEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          memRead = 1'b0;
  logic          memWrite = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] writeData = '0;
  logic [DW-1:0] readData;
  logic          ready;
  logic          busy;
  logic          err;

  dm_responder #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .memRead  (memRead),
    .memWrite (memWrite),
    .address  (address),
    .writeData(writeData),
    .readData (readData),
    .ready    (ready),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          busy;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic r, input logic b,
                              input logic [DW-1:0] q);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.ready = r; v.busy = b; v.rdata = q;
    return v;
  endfunction

  // Drive one request, wait for ready (bounded), then drop it and step past RESP.
  task automatic do_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output logic [DW-1:0] q, output logic e,
                       output int n);
    memRead = rd; memWrite = wr; address = a; writeData = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < 40);
    check("op_done", 32'(ready), 32'd1);
    q = readData;
    e = err;
    memRead = 1'b0; memWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] q;
    logic          e;
    int            n;
    logic          seen;

    // Write 0x1234 to 0x05, then read it back.
    vecs[0]  = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    vecs[1]  = mk(1'b0, 1'b1, 10'h005, 16'h1234, 1'b0, 1'b1, 16'h0000);
    vecs[2]  = mk(1'b0, 1'b1, 10'h005, 16'h1234, 1'b0, 1'b1, 16'h0000);
    vecs[3]  = mk(1'b0, 1'b1, 10'h005, 16'h1234, 1'b0, 1'b1, 16'h0000);
    vecs[4]  = mk(1'b0, 1'b1, 10'h005, 16'h1234, 1'b1, 1'b0, 16'h0000);
    vecs[5]  = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    vecs[6]  = mk(1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b1, 16'h0000);
    vecs[7]  = mk(1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b1, 16'h0000);
    vecs[8]  = mk(1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b1, 16'h0000);
    vecs[9]  = mk(1'b1, 1'b0, 10'h005, 16'h0000, 1'b1, 1'b0, 16'h1234);
    vecs[10] = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'h1234);
    vecs[11] = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'h1234);
    // Read and write together: treated as a write of 0xBEEF to 0x0A.
    vecs[12] = mk(1'b1, 1'b1, 10'h00A, 16'hBEEF, 1'b0, 1'b1, 16'h1234);
    vecs[13] = mk(1'b1, 1'b1, 10'h00A, 16'hBEEF, 1'b0, 1'b1, 16'h1234);
    vecs[14] = mk(1'b1, 1'b1, 10'h00A, 16'hBEEF, 1'b0, 1'b1, 16'h1234);
    vecs[15] = mk(1'b1, 1'b1, 10'h00A, 16'hBEEF, 1'b1, 1'b0, 16'h1234);
    vecs[16] = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'h1234);
    vecs[17] = mk(1'b1, 1'b0, 10'h00A, 16'h0000, 1'b0, 1'b1, 16'h1234);
    vecs[18] = mk(1'b1, 1'b0, 10'h00A, 16'h0000, 1'b0, 1'b1, 16'h1234);
    vecs[19] = mk(1'b1, 1'b0, 10'h00A, 16'h0000, 1'b0, 1'b1, 16'h1234);
    vecs[20] = mk(1'b1, 1'b0, 10'h00A, 16'h0000, 1'b1, 1'b0, 16'hBEEF);
    vecs[21] = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'hBEEF);
    // Address changes to 0x3FF mid-transaction; the latched 0x05 is used.
    // Read held through RESP; the next acceptance is at edge k+LAT+3.
    vecs[22] = mk(1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
    vecs[23] = mk(1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
    vecs[24] = mk(1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
    vecs[25] = mk(1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b1, 1'b0, 16'h1234);
    vecs[26] = mk(1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b0, 1'b0, 16'h1234);
    vecs[27] = mk(1'b1, 1'b0, 10'h00A, 16'h0000, 1'b0, 1'b1, 16'h1234);
    vecs[28] = mk(1'b1, 1'b0, 10'h00A, 16'h0000, 1'b0, 1'b1, 16'h1234);
    vecs[29] = mk(1'b1, 1'b0, 10'h00A, 16'h0000, 1'b0, 1'b1, 16'h1234);
    vecs[30] = mk(1'b1, 1'b0, 10'h00A, 16'h0000, 1'b1, 1'b0, 16'hBEEF);
    vecs[31] = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'hBEEF);

    // Power-on reset.
    #2 rst = 1'b0;
    #10;
    check("reset_state", 32'({ready, busy, err, readData}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++) begin
      memRead   = vecs[i].rd;
      memWrite  = vecs[i].wr;
      address   = vecs[i].addr;
      writeData = vecs[i].wdata;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 32'({ready, busy, err, readData}),
            32'({vecs[i].ready, vecs[i].busy, 1'b0, vecs[i].rdata}));
    end
    memRead = 1'b0;

    // Latency: acceptance edge plus LAT wait edges plus the access edge.
    do_op(1'b0, 1'b1, 10'h007, 16'h1111, q, e, n);
    check("write_latency", 32'(n), 32'(LAT + 2));
    check("write_err", 32'(e), 32'd0);

    // Reset during WAIT of a write of 0xAAAA to 0x07.
    memWrite = 1'b1; address = 10'h007; writeData = 16'hAAAA;
    @(posedge clk); #1;
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_async", 32'({ready, busy, err, readData}), 32'd0);
    memWrite = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen = seen | ready | busy;
    end
    check("idle_no_ready", 32'(seen), 32'd0);
    do_op(1'b1, 1'b0, 10'h007, 16'h0000, q, e, n);
    check("rst_no_commit", 32'(q), 32'h1111);

    // Range behaviour with DEPTH=256: 0x105 aliases 0x005 unless checked.
    do_op(1'b0, 1'b1, 10'h105, 16'h5555, q, e, n);
    check("range_wr_err", 32'(e), 32'(RangeEn));
    do_op(1'b1, 1'b0, 10'h005, 16'h0000, q, e, n);
    check("range_alias_data", 32'(q), RangeEn ? 32'h1234 : 32'h5555);
    check("range_inrange_err", 32'(e), 32'd0);
    do_op(1'b1, 1'b0, 10'h105, 16'h0000, q, e, n);
    check("range_rd_data", 32'(q), RangeEn ? 32'h0000 : 32'h5555);
    check("range_rd_err", 32'(e), 32'(RangeEn));
    check("err_cleared", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Multi-cycle data-memory responder: the target side of the processor's data-memory request interface (memRead/memWrite, 10-bit address, 16-bit data). It accepts one read or write request at a time, holds it for a programmable number of wait cycles, commits or returns data, and signals completion with a one-cycle ready pulse. It replaces the zero-latency data memory when the datapath is moved to a stalling, multi-cycle memory model.

## Interface
- ADDR_W, 10: request address width.
- DATA_W, 16: data word width.
- DEPTH, 1024: number of words; must be a power of two and ≤ 2^ADDR_W.
- LATENCY, 2: wait cycles inserted before access, range 0..15.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- memRead  in  1  read request.
- memWrite  in  1  write request; wins over memRead if both are high.
- address  in  ADDR_W  word address.
- writeData  in  DATA_W  write data.
- readData  out  DATA_W  last read result, held until the next read completes.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  request accepted and not yet completed.
- err  out  1  range error; pulses with ready. Present only with DM_RANGE_CHECK_EN, otherwise tied 0.

## Operation
- Reset (rst=0): state IDLE, wait counter 0, readData=0, ready=0, busy=0, err=0. Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: at an edge with memRead|memWrite=1, latch address, writeData and op (write if memWrite=1), load counter=LATENCY, set busy=1, go to WAIT.
- WAIT: if counter≠0, decrement it. If counter=0, perform access at this edge:
  - write: mem[addr]←data.
  - read: readData←mem[addr].
  - then set ready=1, busy=0, go to RESP.
- RESP: lasts exactly one cycle with ready=1. Then ready=0, err=0, go to IDLE.
- Inputs presented during WAIT or RESP are ignored. The initiator holds the request until ready, then deasserts or changes it. A request still asserted in the cycle after RESP starts a new transaction.
- Address decode without range check: index = address[log2(DEPTH)-1:0]; upper bits are ignored, so the address wraps.
- Reset asserted mid-transaction aborts it. No write is committed, and outputs go to their reset values immediately.
- readData changes only when a read completes. Writes never alter readData, even on a matching address.

## Timing
- A request sampled at edge k:
  - busy=1 after edge k.
  - Access and ready=1 after edge k+LATENCY+1; busy=0 at the same edge.
  - ready=0 after edge k+LATENCY+2.
- Earliest next acceptance is edge k+LATENCY+3, so throughput is one transaction per LATENCY+3 cycles.
- LATENCY=0: ready is high in the cycle after edge k+1.
- readData is valid in the ready cycle and stays stable after it.
- ready and busy are never high together.

## Configuration
- DM_RANGE_CHECK_EN defined: an address ≥ DEPTH is flagged at the access edge.
  - err=1 together with ready.
  - Writes are suppressed.
  - A read loads readData=0.
  - In-range accesses behave normally with err=0.
- Undefined: no range check. Out-of-range addresses wrap modulo DEPTH and err is constant 0.

## Test plan
- Reset: drive rst=0 mid-cycle → readData=0, ready=0, busy=0 asynchronously. Release, then idle 5 cycles → no ready pulse.
- Write/read, LATENCY=2: write 0x1234 to address 0x05, then read 0x05.
  - Each op: busy for 3 cycles, then ready for 1 cycle.
  - The read returns readData=0x1234, held through the following idle cycles.
- Simultaneous memRead=memWrite=1, writeData=0xBEEF at address 0x0A → treated as a write; readData unchanged. A later read of 0x0A returns 0xBEEF.
- Held/ignored inputs: change address to 0x3FF during WAIT and hold memRead through RESP.
  - The access uses the latched address.
  - A second transaction starts exactly at edge k+LATENCY+3.
- Reset mid-op: assert rst=0 during WAIT of a write of 0xAAAA to 0x07 → no ready pulse; a later read of 0x07 returns the prior contents.
- Range, DEPTH=256: write 0x5555 to 0x105.
  - With DM_RANGE_CHECK_EN: err=1 with ready, and a read of 0x005 returns its old value.
  - Without it: a read of 0x005 returns 0x5555.
